serial_add_ctrl: RTL and testbench

//   Sequences a single 1-bit full-adder cell over WIDTH cycles to add two

---
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             cell_s;
    logic             cell_c;
    logic [CW-1:0]    cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared full-adder cell; the sum bit enters the result at the MSB
    always_comb begin
        cell_s   = op_a[0] ^ op_b[0] ^ carry;
        cell_c   = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        res_next = (res >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            ready <= (state_next != RUN);
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (accept) begin
                op_a  <= a;
                op_b  <= b;
                carry <= cin;
                res   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                res   <= res_next;
                carry <= cell_c;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum  <= res_next;
                    cout <= cell_c;
`ifdef SERIAL_ADD_OVF_EN
                    // carry still holds the carry into the MSB on the last step
                    ovf  <= carry ^ cell_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH 1, 8 and 13.
// Honours SERIAL_ADD_OVF_EN for the overflow output.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        w1_start = 1'b0, w1_a = 1'b0, w1_b = 1'b0, w1_cin = 1'b0;
    logic        w1_ready, w1_busy, w1_done, w1_sum, w1_cout;
    logic        w8_start = 1'b0, w8_cin = 1'b0;
    logic [7:0]  w8_a = '0, w8_b = '0, w8_sum;
    logic        w8_ready, w8_busy, w8_done, w8_cout;
    logic        w13_start = 1'b0, w13_cin = 1'b0;
    logic [12:0] w13_a = '0, w13_b = '0, w13_sum;
    logic        w13_ready, w13_busy, w13_done, w13_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic        w1_ovf, w8_ovf, w13_ovf;
`endif

    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(w1_start), .a(w1_a), .b(w1_b), .cin(w1_cin),
        .ready(w1_ready), .busy(w1_busy), .done(w1_done), .sum(w1_sum), .cout(w1_cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(w1_ovf)
`endif
    );

    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(w8_start), .a(w8_a), .b(w8_b), .cin(w8_cin),
        .ready(w8_ready), .busy(w8_busy), .done(w8_done), .sum(w8_sum), .cout(w8_cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(w8_ovf)
`endif
    );

    serial_add_ctrl #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst(rst), .start(w13_start), .a(w13_a), .b(w13_b), .cin(w13_cin),
        .ready(w13_ready), .busy(w13_busy), .done(w13_done), .sum(w13_sum), .cout(w13_cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(w13_ovf)
`endif
    );

    task automatic test_reset();
        w8_start = 1'b1;
        w8_a     = 8'hAA;
        w8_b     = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (w8_ready !== 1'b1 || w8_busy !== 1'b0 || w8_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got rdy=%b busy=%b done=%b exp 1 0 0", w8_ready, w8_busy, w8_done);
        end
        checks++;
        if (w8_sum !== 8'h00 || w8_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_sum got %h/%b exp 00/0", w8_sum, w8_cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (w8_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b exp 0", w8_ovf);
        end
`endif
        rst      = 1'b0;
        w8_start = 1'b0;
        @(negedge clk);
        checks++;
        if (w8_busy !== 1'b0 || w8_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got busy=%b rdy=%b exp 0 1", w8_busy, w8_ready);
        end
    endtask

    task automatic test_width1();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic       es, ec;
            v  = 3'(i);
            es = v[2] ^ v[1] ^ v[0];
            ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            w1_start = 1'b1;
            w1_a     = v[2];
            w1_b     = v[1];
            w1_cin   = v[0];
            @(negedge clk);
            w1_start = 1'b0;
            checks++;
            if (w1_busy !== 1'b1 || w1_done !== 1'b0) begin
                errors++;
                $display("FAIL w1_busy[%0d] got busy=%b done=%b exp 1 0", i, w1_busy, w1_done);
            end
            @(negedge clk);
            checks++;
            if (w1_done !== 1'b1 || w1_sum !== es || w1_cout !== ec) begin
                errors++;
                $display("FAIL w1_add[%0d] got done=%b sum=%b cout=%b exp 1 %b %b",
                         i, w1_done, w1_sum, w1_cout, es, ec);
            end
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
        int busy_cnt;
        checks++;
        if (w8_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b exp 1", nm, w8_ready);
        end
        w8_start = 1'b1;
        w8_a     = a;
        w8_b     = b;
        w8_cin   = ci;
        busy_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            w8_start = 1'b0;
            w8_a     = ~a;
            w8_b     = ~b;
            w8_cin   = ~ci;
            if (w8_busy === 1'b1 && w8_done === 1'b0) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d exp 8", nm, busy_cnt);
        end
        @(negedge clk);
        checks++;
        if (w8_done !== 1'b1 || w8_busy !== 1'b0 || w8_sum !== es || w8_cout !== ec) begin
            errors++;
            $display("FAIL %s_result got done=%b busy=%b sum=%h cout=%b exp 1 0 %h %b",
                     nm, w8_done, w8_busy, w8_sum, w8_cout, es, ec);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (w8_ovf !== eo) begin
            errors++;
            $display("FAIL %s_ovf got %b exp %b", nm, w8_ovf, eo);
        end
`else
        if (eo === 1'bx) $display("note: eo unknown");
`endif
        @(negedge clk);
        checks++;
        if (w8_done !== 1'b0 || w8_sum !== es) begin
            errors++;
            $display("FAIL %s_hold got done=%b sum=%h exp 0 %h", nm, w8_done, w8_sum, es);
        end
    endtask

    task automatic test_carry_wrap();
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
    endtask

    task automatic test_overflow();
        run8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "ovf");
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        w8_start = 1'b1;
        w8_a     = 8'h05;
        w8_b     = 8'h0A;
        w8_cin   = 1'b0;
        busy_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            w8_a = 8'h12;
            w8_b = 8'h34;
            if (w8_busy === 1'b1) busy_cnt++;
        end
        @(negedge clk);
        checks++;
        if (busy_cnt != 8 || w8_done !== 1'b1 || w8_ready !== 1'b1 || w8_sum !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_first got busy_cnt=%0d done=%b rdy=%b sum=%h exp 8 1 1 0f",
                     busy_cnt, w8_done, w8_ready, w8_sum);
        end
        @(negedge clk);
        w8_start = 1'b0;
        checks++;
        if (w8_busy !== 1'b1 || w8_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nobubble got busy=%b done=%b exp 1 0", w8_busy, w8_done);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (w8_done !== 1'b1 || w8_sum !== 8'h46 || w8_cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got done=%b sum=%h cout=%b exp 1 46 0", w8_done, w8_sum, w8_cout);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int dones;
        w8_start = 1'b1;
        w8_a     = 8'h21;
        w8_b     = 8'h43;
        w8_cin   = 1'b1;
        @(negedge clk);
        w8_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (w8_ready !== 1'b1 || w8_busy !== 1'b0 || w8_done !== 1'b0 ||
            w8_sum !== 8'h00 || w8_cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got rdy=%b busy=%b done=%b sum=%h cout=%b exp 1 0 0 00 0",
                     w8_ready, w8_busy, w8_done, w8_sum, w8_cout);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w8_done !== 1'b0 || w8_busy !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles exp 0", dones);
        end
    endtask

    task automatic test_random8();
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] ex;
            int         cyc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ex = 9'(ra) + 9'(rb) + 9'(rc);
            w8_start = 1'b1;
            w8_a     = ra;
            w8_b     = rb;
            w8_cin   = rc;
            @(negedge clk);
            w8_start = 1'b0;
            w8_a     = 8'($urandom);
            cyc = 1;
            while (w8_done !== 1'b1 && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != 9 || {w8_cout, w8_sum} !== ex) begin
                errors++;
                $display("FAIL rand8[%0d] got cyc=%0d res=%h exp 9 %h", n, cyc, {w8_cout, w8_sum}, ex);
            end
`ifdef SERIAL_ADD_OVF_EN
            begin
                logic [7:0] lo;
                lo = 8'({1'b0, ra[6:0]}) + 8'({1'b0, rb[6:0]}) + 8'(rc);
                checks++;
                if (w8_ovf !== (lo[7] ^ ex[8])) begin
                    errors++;
                    $display("FAIL rand8_ovf[%0d] got %b exp %b", n, w8_ovf, lo[7] ^ ex[8]);
                end
            end
`endif
            @(negedge clk);
            checks++;
            if (w8_done !== 1'b0) begin
                errors++;
                $display("FAIL rand8_single[%0d] got done=%b exp 0", n, w8_done);
            end
        end
    endtask

    task automatic test_random13();
        for (int n = 0; n < 300; n++) begin
            logic [12:0] ra, rb;
            logic        rc;
            logic [13:0] ex;
            int          cyc;
            ra = 13'($urandom);
            rb = 13'($urandom);
            rc = 1'($urandom);
            ex = 14'(ra) + 14'(rb) + 14'(rc);
            w13_start = 1'b1;
            w13_a     = ra;
            w13_b     = rb;
            w13_cin   = rc;
            @(negedge clk);
            w13_start = 1'b0;
            w13_b     = 13'($urandom);
            cyc = 1;
            while (w13_done !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != 14 || {w13_cout, w13_sum} !== ex) begin
                errors++;
                $display("FAIL rand13[%0d] got cyc=%0d res=%h exp 14 %h", n, cyc, {w13_cout, w13_sum}, ex);
            end
            @(negedge clk);
            checks++;
            if (w13_done !== 1'b0) begin
                errors++;
                $display("FAIL rand13_single[%0d] got done=%b exp 0", n, w13_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_width1();
        test_carry_wrap();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_random8();
        test_random13();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
